// File: rtl/dac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dac_pkg
//  Description : Shared encodings and waveform arithmetic for the DAC sample
//                sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package dac_pkg;

  // Waveform select encodings
  localparam logic [1:0] WAVE_SAW = 2'b00;
  localparam logic [1:0] WAVE_TRI = 2'b01;
  localparam logic [1:0] WAVE_SQR = 2'b10;
  localparam logic [1:0] WAVE_DC  = 2'b11;

  // Value placed on dac_control unless overridden
  localparam logic [7:0] DEFAULT_CONTROL_BYTE = 8'h00;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } seq_state_e;

  // Result of advancing the waveform by one accepted sample
  typedef struct packed {
    logic [7:0] acc;
    logic       dir_up;
    logic [7:0] data;
  } wave_next_t;

  // Next phase/direction/sample for one accepted tick. The 9-bit sum gives
  // the triangle its saturation flag; sawtooth and square wrap mod 256.
  function automatic wave_next_t wave_step(input logic [1:0] sel,
                                           input logic [7:0] acc,
                                           input logic       dir_up,
                                           input logic [7:0] step);
    wave_next_t r;
    logic [8:0] sum;
    r.acc    = acc;
    r.dir_up = dir_up;
    r.data   = 8'h00;
    sum      = {1'b0, acc} + {1'b0, step};
    case (sel)
      WAVE_SAW: begin
        r.acc  = sum[7:0];
        r.data = sum[7:0];
      end
      WAVE_SQR: begin
        r.acc  = sum[7:0];
        r.data = sum[7] ? 8'hFF : 8'h00;
      end
      WAVE_TRI: begin
        if (dir_up) begin
          if (sum[8]) begin
            r.acc    = 8'hFF;
            r.dir_up = 1'b0;
          end else begin
            r.acc = sum[7:0];
          end
        end else begin
          if (acc < step) begin
            r.acc    = 8'h00;
            r.dir_up = 1'b1;
          end else begin
            r.acc = acc - step;
          end
        end
        r.data = r.acc;
      end
      default: begin
        // DC: level comes straight from step, phase state untouched
        r.data = step;
      end
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dac_sample_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : dac_sample_sequencer_if
//  Description : Sample/handshake bundle between the sequencer and dac_driver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dac_sample_sequencer_if;
  logic [7:0] dac_data;
  logic [7:0] dac_control;
  logic       dac_begin;
  logic       dac_sync;

  modport master (output dac_data, output dac_control, output dac_begin,
                  input  dac_sync);
  modport slave  (input  dac_data, input  dac_control, input  dac_begin,
                  output dac_sync);
endinterface
`default_nettype wire

// File: rtl/rate_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : rate_tick_gen
//  Description : Programmable sample-rate divider; one tick every
//                rate_div+1 enabled clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module rate_tick_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 enable,
  input  wire logic [DIV_WIDTH-1:0] rate_div,
  output logic                      tick
);

  logic [DIV_WIDTH-1:0] div_cnt_q;

  // Divider counter: held at 0 while disabled, wraps after reaching rate_div.
  // Wrapping on >= keeps the counter sane if rate_div is lowered mid-count.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      div_cnt_q <= '0;
    end else if (div_cnt_q >= rate_div) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
    end
  end

  assign tick = enable && (div_cnt_q == rate_div);

endmodule
`default_nettype wire

// File: rtl/dac_sample_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dac_sample_sequencer
//  Description : Periodic waveform sample generator feeding dac_driver; one
//                SPI frame per accepted sample, late samples dropped/flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_sample_sequencer
  import dac_pkg::*;
#(
  parameter int         DIV_WIDTH    = 16,
  parameter logic [7:0] CONTROL_BYTE = DEFAULT_CONTROL_BYTE
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 enable,
  input  wire logic [1:0]           wave_sel,
  input  wire logic [7:0]           step,
  input  wire logic [DIV_WIDTH-1:0] rate_div,
  output logic                      busy,
  output logic                      sample_missed,
  dac_sample_sequencer_if.master    dac
);

  logic       tick;
  seq_state_e state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] data_q, data_d;
  logic       dir_up_q, dir_up_d;
  logic       begin_q, begin_d;
  logic       missed;
  wave_next_t wave_nxt;

  rate_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_rate_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .rate_div (rate_div),
    .tick     (tick)
  );

  assign wave_nxt = wave_step(wave_sel, acc_q, dir_up_q, step);

  // State, phase and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= 8'h00;
      dir_up_q <= 1'b1;
      data_q   <= 8'h00;
      begin_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      dir_up_q <= dir_up_d;
      data_q   <= data_d;
      begin_q  <= begin_d;
    end
  end

  // Next-state logic: accept a tick only when idle and the driver is free;
  // any other tick is dropped without touching the phase.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    dir_up_d = dir_up_q;
    data_d   = data_q;
    begin_d  = begin_q;
    missed   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          if (dac.dac_sync) begin
            acc_d    = wave_nxt.acc;
            dir_up_d = wave_nxt.dir_up;
            data_d   = wave_nxt.data;
            begin_d  = 1'b1;
            state_d  = ST_REQ;
          end else begin
            missed = 1'b1;
          end
        end
      end
      ST_REQ: begin
        missed = tick;
        if (!dac.dac_sync) begin
          begin_d = 1'b0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        missed = tick;
        if (dac.dac_sync) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        begin_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy            = (state_q != ST_IDLE);
  assign sample_missed   = missed;
  assign dac.dac_data    = data_q;
  assign dac.dac_control = CONTROL_BYTE;
  assign dac.dac_begin   = begin_q;

endmodule
`default_nettype wire

// File: doc/dac_sample_sequencer.md
# dac_sample_sequencer

- Upstream stage of `dac_driver`.
- Generates a periodic 8-bit waveform sample stream at a programmable sample rate.
- For each sample it presents the data and control bytes and handshakes on `dac_begin`/`dac_sync`, so exactly one 16-bit SPI frame is launched per sample.
- Samples that fall due while a frame is still in flight are dropped and flagged.

## Interface
Parameters:
- `DIV_WIDTH`, 16, width of the sample-rate divider.
- `CONTROL_BYTE`, 8'h00, constant value driven on `dac_control`.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `enable` input 1: high lets the rate divider run and samples issue.
- `wave_sel` input 2: waveform select. 00 sawtooth, 01 triangle, 10 square, 11 DC.
- `step` input 8: phase increment per sample; DC level when `wave_sel`=11.
- `rate_div` input DIV_WIDTH: sample period is `rate_div`+1 clocks.
- `dac_sync` input 1: frame-active-low status from `dac_driver`.
- `dac_data` output 8: current sample.
- `dac_control` output 8: always `CONTROL_BYTE`.
- `dac_begin` output 1: frame request to `dac_driver`.
- `busy` output 1: high from request until frame completion is seen.
- `sample_missed` output 1: one-cycle pulse when a due sample is dropped.

## Operation
- **Rate divider:**
  - Counter `div_cnt` runs 0..`rate_div` while `enable`=1, then wraps to 0.
  - `tick` is high in the cycle `div_cnt`==`rate_div`.
  - `enable`=0 holds `div_cnt` at 0 and suppresses `tick`.
  - `rate_div`=0 gives a tick every cycle.
- **FSM states:**
  - IDLE: on `tick` and `dac_sync`=1, compute the next sample, load `dac_data`, set `dac_begin`=1, go to REQ.
  - IDLE: on `tick` and `dac_sync`=0 (driver still busy from an earlier frame), pulse `sample_missed` and stay in IDLE.
  - REQ: hold `dac_begin`=1 until `dac_sync`=0 is sampled, then clear `dac_begin` and go to XFER.
  - XFER: wait for `dac_sync`=1, then go to IDLE.
  - Any `tick` while in REQ or XFER pulses `sample_missed`; the sample is not generated and the phase is not advanced.
  - `busy` = (state != IDLE).
- **Waveform arithmetic** (8-bit unsigned, evaluated only on an accepted tick):
  - Phase accumulator `acc`.
  - Sawtooth: `acc` <= `acc`+`step` mod 256; `dac_data` = new `acc`.
  - Square: `acc` advances as sawtooth; `dac_data` = 8'hFF if new `acc`[7] else 8'h00.
  - Triangle, direction bit `dir_up`:
    - Up: if `acc`+`step` > 255 (9-bit sum), then `acc`=255 and `dir_up`=0; else add.
    - Down: if `acc` < `step`, then `acc`=0 and `dir_up`=1; else subtract.
    - `dac_data` = new `acc`.
  - DC: `dac_data` = `step`; `acc` and `dir_up` unchanged.
  - `step`=0 freezes sawtooth, square and triangle at the current value.
  - A `wave_sel` change takes effect on the next accepted tick; `acc` and `dir_up` are not cleared.
- **Reset values:**
  - `dac_data`=0, `dac_control`=`CONTROL_BYTE`, `dac_begin`=0, `busy`=0, `sample_missed`=0.
  - `acc`=0, `dir_up`=1, `div_cnt`=0, state IDLE.
- **Reset mid-frame:**
  - `dac_begin` drops on the reset edge.
  - `dac_driver` has no reset and finishes its frame; the sequencer then sees `dac_sync`=0 on ticks and reports misses until the frame ends.
- **Deassert of `enable` mid-frame:** the in-flight frame completes normally; no new requests are made.

## Timing
- Tick in cycle T → `dac_data` valid and `dac_begin`=1 from edge T+1.
- `dac_data` is stable from the request until the next accepted tick; it never changes while `busy`=1.
- `dac_driver` samples on the falling edge, so `dac_sync` normally falls mid-cycle T+1 and `dac_begin` clears at edge T+2. `dac_begin` is high for at least one full cycle.
- A frame occupies about 17 clocks; `rate_div` ≥ 18 sustains one frame per tick with no misses.
- `sample_missed` is high for exactly the tick cycle.

## Structure
- Package `dac_pkg`:
  - Waveform-select encodings (`WAVE_SAW`, `WAVE_TRI`, `WAVE_SQR`, `WAVE_DC`).
  - FSM state encoding (IDLE/REQ/XFER).
  - Default `CONTROL_BYTE`.
- Sub-module `rate_tick_gen`: parameterised by `DIV_WIDTH`; inputs `clk`, `reset`, `enable`, `rate_div`; output `tick`.
- FSM and waveform datapath stay in the top module.

## Test plan
- Bench models `dac_driver` behaviourally: `dac_sync` falls on the first falling edge that sees `dac_begin`, rises 16 falling edges later.
- Reset, then `enable`=1, `wave_sel`=00, `step`=8'h40, `rate_div`=31 → `dac_data` sequence 40,80,C0,00,40; a request every 32 clocks; `sample_missed` never pulses.
- `wave_sel`=01, `step`=8'h70, `rate_div`=31 → `dac_data` 70,E0,FF,8F,1F,00,70 (saturates at 255 and at 0, reverses direction).
- `wave_sel`=10, `step`=8'h80 → `dac_data` alternates FF,00,FF; `wave_sel`=11, `step`=8'h5A → constant 5A.
- `rate_div`=4 with sawtooth `step`=1 → accepted samples increment by exactly 1 despite misses; `sample_missed` pulses on every tick during REQ/XFER.
- Assert `reset` two cycles after a request, with the model mid-frame → outputs return to reset values next edge; ticks pulse `sample_missed` until model `dac_sync`=1, then normal requests resume starting at `dac_data`=01.
